// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, ALU function codes and controller states
// shared by the multicycle MIPS control path.
package mips_pkg;

    typedef enum logic [2:0] {
        AND = 3'b000,
        OR  = 3'b001,
        ADD = 3'b010,
        SLL = 3'b011,
        SUB = 3'b110,
        SLT = 3'b111
    } alu_f_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps an R-type funct field to the ALU function code and flags
// funct values the datapath does not support.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_f_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_f_o = ADD;
            FN_SUB:  alu_f_o = SUB;
            FN_AND:  alu_f_o = AND;
            FN_OR:   alu_f_o = OR;
            FN_SLT:  alu_f_o = SLT;
            FN_SLL:  alu_f_o = SLL;
            default: begin
                alu_f_o = ADD;
                valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM sequencing the shared multicycle
// MIPS datapath through fetch/decode/execute/memory/writeback.
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    output logic       pc_en_o,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       iord_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] alu_f_o,
    output logic       illegal_o
);

    state_t     state_q, state_d;
    logic [2:0] fn_alu_f;
    logic       fn_valid, op_valid, pc_write, branch;

    alu_decoder u_alu_decoder (
        .funct_i (funct_i),
        .alu_f_o (fn_alu_f),
        .valid_o (fn_valid)
    );

    assign op_valid = op_i inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

    always_ff @(posedge clk_i) begin
        state_q <= rst_n_i ? state_d : FETCH;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = op_i == OP_LW ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Everything is held inactive while reset is asserted, whatever the state.
    always_comb begin
        pc_write     = 1'b0;
        branch       = 1'b0;
        ir_write_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        pc_src_o     = 2'b00;
        alu_f_o      = ADD;
        illegal_o    = 1'b0;
        if (rst_n_i) begin
            case (state_q)
                FETCH: begin
                    ir_write_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    pc_write    = 1'b1;
                end
                DECODE: begin
                    alu_src_b_o = 2'b11;
                    illegal_o   = !op_valid || (op_i == OP_RTYPE && !fn_valid);
                end
                MEMADR, ADDIEX: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                MEMRD: iord_o = 1'b1;
                MEMWB: begin
                    mem_to_reg_o = 1'b1;
                    reg_write_o  = 1'b1;
                end
                MEMWR: begin
                    iord_o      = 1'b1;
                    mem_write_o = 1'b1;
                end
                EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_f_o     = fn_alu_f;
                end
                ALUWB: begin
                    reg_dst_o   = 1'b1;
                    reg_write_o = fn_valid;
                end
                BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_f_o     = SUB;
                    branch      = 1'b1;
                    pc_src_o    = 2'b01;
                end
                ADDIWB: reg_write_o = 1'b1;
                JUMP: begin
                    pc_src_o = 2'b10;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
        pc_en_o = pc_write | (branch & zero_i);
    end

endmodule
